// File: rtl/axi_mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single SRAM-like memory port, one transaction in flight.
// Build option: define ARB_RR_EN to alternate grants when both requesters contend in IDLE.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_ok,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner_q, last_owner_d;

    logic any_req;
    logic sel_data;
    logic cur_owner;
    logic issue;
    logic addr_hs;
    logic done;

    assign any_req = inst_req | data_req;

`ifdef ARB_RR_EN
    // Under contention the requester that did not own the last transaction wins.
    assign sel_data = data_req & (~inst_req | ~last_owner_q);
`else
    assign sel_data = data_req;
    logic unused_last_owner;
    assign unused_last_owner = last_owner_q;
`endif

    // In IDLE the choice is made combinationally so the request leaves in the same cycle.
    assign cur_owner = (state_q == IDLE) ? sel_data : owner_q;
    assign issue     = rst & (((state_q == IDLE) & any_req) | (state_q == ADDR));
    assign addr_hs   = issue & mem_addr_ok;
    assign done      = rst & (state_q == WAIT) & mem_data_ok;

    assign mem_req   = issue;
    assign mem_wr    = issue & cur_owner & data_wr;
    assign mem_size  = !issue ? 2'd0 : (cur_owner ? data_size : 2'd2);
    assign mem_addr  = !issue ? '0 : (cur_owner ? data_addr : inst_addr);
    assign mem_wdata = (issue & cur_owner) ? data_wdata : '0;

    assign inst_addr_ok = addr_hs & ~cur_owner;
    assign data_addr_ok = addr_hs & cur_owner;
    assign inst_data_ok = done & ~owner_q;
    assign data_data_ok = done & owner_q;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign busy = rst & ((state_q != IDLE) | any_req);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel_data;
                    state_d = mem_addr_ok ? WAIT : ADDR;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Completions seen outside WAIT are spurious and never reach this branch.
                if (mem_data_ok) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: directed cycle sequences plus a completion scoreboard on the *_data_ok outputs.
module tb_axi_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_data_ok;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              data_data_ok;
    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_ok;
    logic              busy;

    axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
        .mem_data_ok(mem_data_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Completion scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_owner", {63'd0, data_data_ok}, {63'd0, e.owner});
                chk("sb_rdata", {32'd0, (e.owner ? data_rdata : inst_rdata)}, {32'd0, e.rdata});
                chk("sb_other_ok", {63'd0, (e.owner ? inst_data_ok : data_data_ok)}, 64'd0);
                chk("sb_other_rdata", {32'd0, (e.owner ? inst_rdata : data_rdata)}, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic        first_data;
    logic [31:0] a1, a2;

    initial begin
`ifdef ARB_RR_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1234_5678;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h8765_4321; data_wdata = 32'hFFFF_FFFF;
        mem_addr_ok = 1'b1; mem_rdata = 32'hA5A5_A5A5; mem_data_ok = 1'b1;

        // Reset with every input active: all outputs forced low.
        cyc(); #1;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_mem_wr_size", {61'd0, mem_wr, mem_size}, 64'd0);
        chk("rst_addr_oks", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        chk("rst_data_oks", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        cyc();
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = '0; data_wdata = '0; inst_addr = '0;
        mem_addr_ok = 1'b0; mem_rdata = '0; mem_data_ok = 1'b0;
        rst = 1'b1;
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Single fetch, address accepted immediately, data three cycles later.
        cyc();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
        #1;
        chk("f_mem_req", {63'd0, mem_req}, 64'd1);
        chk("f_mem_addr", {32'd0, mem_addr}, {32'd0, 32'hBFC0_0000});
        chk("f_mem_wr_size", {61'd0, mem_wr, mem_size}, 64'd2);
        chk("f_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("f_inst_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd2);
        push_exp(1'b0, 32'h3C1D_8000);
        cyc();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("f_wait_req", {63'd0, mem_req}, 64'd0);
        chk("f_wait_busy", {63'd0, busy}, 64'd1);
        cyc();
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_8000;
        #1;
        chk("f_inst_data_ok", {63'd0, inst_data_ok}, 64'd1);
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;

        // Byte write with a one-cycle address wait.
        cyc();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_2003; data_wdata = 32'h0000_00AB;
        #1;
        chk("w_mem_req", {63'd0, mem_req}, 64'd1);
        chk("w_mem_wr_size", {61'd0, mem_wr, mem_size}, 64'd4);
        chk("w_mem_addr", {32'd0, mem_addr}, {32'd0, 32'h8000_2003});
        chk("w_mem_wdata", {32'd0, mem_wdata}, 64'hAB);
        chk("w_no_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        cyc();
        mem_addr_ok = 1'b1;
        #1;
        chk("w_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd1);
        chk("w_addr_hold", {32'd0, mem_addr}, {32'd0, 32'h8000_2003});
        push_exp(1'b1, 32'h1122_3344);
        cyc();
        data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h1122_3344;
        #1;
        chk("w_data_ok", {63'd0, data_data_ok}, 64'd1);
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;

        // Simultaneous requests; the last owner was the data side.
        a1 = first_data ? 32'h8000_1000 : 32'hBFC0_0004;
        a2 = first_data ? 32'hBFC0_0004 : 32'h8000_1000;
        cyc();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
        mem_addr_ok = 1'b1;
        #1;
        chk("s_first_addr", {32'd0, mem_addr}, {32'd0, a1});
        chk("s_first_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, first_data ? 64'd1 : 64'd2);
        push_exp(first_data, 32'hCAFE_0001);
        cyc();
        if (first_data) data_req = 1'b0; else inst_req = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        chk("s_wait_req", {63'd0, mem_req}, 64'd0);
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk("s_no_overlap", {63'd0, mem_req}, 64'd0);
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0; mem_addr_ok = 1'b1;
        #1;
        chk("s_second_addr", {32'd0, mem_addr}, {32'd0, a2});
        chk("s_second_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, first_data ? 64'd2 : 64'd1);
        push_exp(~first_data, 32'hCAFE_0002);
        cyc();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0002;
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;

        // Grant lock: fetch waits four cycles for its address; data arrives meanwhile.
        for (int c = 0; c < 4; c++) begin
            cyc();
            inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
            if (c == 2) begin
                data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_3000;
            end
            #1;
            chk("l_addr_locked", {32'd0, mem_addr}, {32'd0, 32'hBFC0_0008});
            chk("l_no_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        end
        cyc();
        mem_addr_ok = 1'b1;
        #1;
        chk("l_inst_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd2);
        push_exp(1'b0, 32'h0000_0BAD);
        cyc();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0BAD;
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0; mem_addr_ok = 1'b1;
        #1;
        chk("l_data_addr", {32'd0, mem_addr}, {32'd0, 32'h8000_3000});
        chk("l_data_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd1);
        push_exp(1'b1, 32'h5555_AAAA);
        cyc();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;

        // Spurious completion in IDLE, then reset while a fetch is in WAIT.
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("sp_busy", {63'd0, busy}, 64'd0);
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010; mem_addr_ok = 1'b1;
        #1;
        chk("sp_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd2);
        cyc();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("sp_wait_busy", {63'd0, busy}, 64'd1);
        cyc();
        rst = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("mr_mem_req", {63'd0, mem_req}, 64'd0);
        chk("mr_oks", {60'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
        chk("mr_rdata", {inst_rdata, data_rdata}, 64'd0);
        chk("mr_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("mr_busy", {63'd0, busy}, 64'd0);
        cyc();
        rst = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("ar_busy", {63'd0, busy}, 64'd0);
        chk("ar_mem_req", {63'd0, mem_req}, 64'd0);
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;
        // A fresh fetch is granted at once, which only happens from IDLE.
        cyc();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0020; mem_addr_ok = 1'b1;
        #1;
        chk("ar_regrant", {62'd0, inst_addr_ok, mem_req}, 64'd3);
        push_exp(1'b0, 32'h0BAD_F00D);
        cyc();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;
        cyc();
        cyc();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
